// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter with a small TX FIFO and zero-gap back-to-back frames.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_gen #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BAUD_DIV   = 2604,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef UART_TX_BREAK_EN
    input  logic              send_break,
`endif
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    output logic              TX,
    output logic              tx_done,
    output logic              busy,
    output logic              full
);

    localparam int unsigned SHIFT_W    = DATA_W + 3;
    localparam int unsigned FRAME_BITS = 1 + DATA_W + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int unsigned BAUD_W     = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    // LOAD is the one-cycle pop/fetch step between IDLE and the first bit of a frame.
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t              state, state_next;
    logic [SHIFT_W-1:0]  shift;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [SHIFT_W-1:0]  load_word;
    logic                push, pop, load, set_done, brk_drive;
    logic                shift_tick, last_bit, fifo_empty, par_bit, hold_break;

`ifdef UART_TX_BREAK_EN
    assign hold_break = send_break;
`else
    assign hold_break = 1'b0;
`endif

    assign TX         = shift[0];
    assign fifo_empty = (count == '0);
    assign push       = trmt && !full;
    assign shift_tick = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
    assign last_bit   = shift_tick && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Frame image: a trailing fill of ones supplies any stop bit beyond the register width.
    always_comb begin
        par_bit = 1'b1;
        if (PARITY == 1) par_bit = ^mem[rd_ptr];
        else if (PARITY == 2) par_bit = ~^mem[rd_ptr];
        load_word = {1'b1, par_bit, mem[rd_ptr], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        set_done   = 1'b0;
        brk_drive  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_break)       brk_drive  = 1'b1;
                else if (!fifo_empty) state_next = LOAD;
            end
            LOAD: begin
                pop        = 1'b1;
                load       = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (last_bit) begin
                    if (!fifo_empty && !hold_break) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                        set_done   = fifo_empty;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shifter and bit timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            shift    <= load_word;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state == SEND) begin
            if (shift_tick) begin
                shift    <= {1'b1, shift[SHIFT_W-1:1]};
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end else begin
            shift    <= brk_drive ? {{(SHIFT_W-1){1'b1}}, 1'b0} : '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            busy  <= (state_next != IDLE) || (count_next != '0) || hold_break;
            // An accepted push always beats a completing frame.
            if (push)          tx_done <= 1'b0;
            else if (set_done) tx_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: three parameterisations share one stimulus
// stream and are checked every cycle against a timeline-based frame model.
module tb_uart_tx_gen;

    localparam int N = 3;
    localparam int CDW [N]  = '{8, 8, 5};
    localparam int CBD [N]  = '{16, 16, 4};
    localparam int CPAR[N]  = '{0, 1, 2};
    localparam int CSTP[N]  = '{1, 2, 1};
    localparam int CDEP[N]  = '{4, 4, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_w [N];
    logic       done_w [N];
    logic       busy_w [N];
    logic       full_w [N];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int mq     [N][16];
    int mcount [N];
    int mstart [N];
    int mcur   [N];
    bit mactive[N];
    bit mpend  [N];
    bit mdone  [N];

    always #5 clk = ~clk;

    uart_tx_gen #(.DATA_W(8), .BAUD_DIV(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
        .TX(tx_w[0]), .tx_done(done_w[0]), .busy(busy_w[0]), .full(full_w[0]));

    uart_tx_gen #(.DATA_W(8), .BAUD_DIV(16), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
        .TX(tx_w[1]), .tx_done(done_w[1]), .busy(busy_w[1]), .full(full_w[1]));

    uart_tx_gen #(.DATA_W(5), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data[4:0]),
        .TX(tx_w[2]), .tx_done(done_w[2]), .busy(busy_w[2]), .full(full_w[2]));

    function automatic int frame_bits(int i);
        return 1 + CDW[i] + ((CPAR[i] != 0) ? 1 : 0) + CSTP[i];
    endfunction

    // Bit idx of the serial frame carrying word d: start, data LSB first, parity, stops.
    function automatic logic frame_bit(int i, int d, int idx);
        int ones;
        ones = $countones(d);
        if (idx == 0) return 1'b0;
        if (idx <= CDW[i]) return logic'((d >> (idx - 1)) & 1);
        if (idx == CDW[i] + 1 && CPAR[i] == 1) return logic'(ones % 2 == 1);
        if (idx == CDW[i] + 1 && CPAR[i] == 2) return logic'(ones % 2 == 0);
        return 1'b1;
    endfunction

    function automatic int pop_word(int i);
        int w;
        w = mq[i][0];
        for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
        mcount[i]--;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mcount[i] = 0; mstart[i] = 0; mcur[i] = 0;
            mactive[i] = 0; mpend[i] = 0; mdone[i] = 0;
        end
    endtask

    // One rising edge: frames last frame_bits*baud clocks, next queued word starts at
    // the ending edge, an idle transmitter starts two edges after the word was queued.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit acc;
            acc = trmt && (mcount[i] != CDEP[i]);
            if (mactive[i] && cyc == mstart[i] + frame_bits(i) * CBD[i]) begin
                if (mcount[i] > 0) begin
                    mcur[i] = pop_word(i);
                    mstart[i] = cyc;
                end else begin
                    mactive[i] = 0;
                    mdone[i] = 1;
                end
            end else if (mpend[i]) begin
                mpend[i] = 0;
                mactive[i] = 1;
                mstart[i] = cyc;
                mcur[i] = pop_word(i);
            end else if (!mactive[i] && mcount[i] > 0) begin
                mpend[i] = 1;
            end
            if (acc) begin
                mq[i][mcount[i]] = int'(tx_data) & ((1 << CDW[i]) - 1);
                mcount[i]++;
                mdone[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic etx;
            etx = mactive[i] ? frame_bit(i, mcur[i], (cyc - mstart[i]) / CBD[i]) : 1'b1;
            chk("tx", i, tx_w[i], etx);
            chk("busy", i, busy_w[i], logic'(mactive[i] || mpend[i] || mcount[i] > 0));
            chk("full", i, full_w[i], logic'(mcount[i] == CDEP[i]));
            chk("tx_done", i, done_w[i], logic'(mdone[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push(input logic [7:0] d);
        trmt = 1'b1;
        tx_data = d;
        step();
        trmt = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_tx", i, tx_w[i], 1'b1);
            chk("rst_busy", i, busy_w[i], 1'b0);
            chk("rst_full", i, full_w[i], 1'b0);
            chk("rst_done", i, done_w[i], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        steps(3);

        // Single 8N1 frame: start two edges after the push, tx_done after 160 clocks.
        push(8'hA5);
        step();
        chk("lat_high", 0, tx_w[0], 1'b1);
        step();
        chk("lat_low", 0, tx_w[0], 1'b0);
        steps(159);
        chk("done_early", 0, done_w[0], 1'b0);
        step();
        chk("done_end", 0, done_w[0], 1'b1);
        steps(140);

        // Parity bit of 0x07: even parity 1, odd parity 0.
        push(8'h07);
        steps(27);
        chk("par_odd", 2, tx_w[2], 1'b0);
        steps(120);
        chk("par_even", 1, tx_w[1], 1'b1);
        steps(200);

        // Burst of six pushes: FIFO fills, sixth is dropped, frames go out gapless.
        for (int k = 0; k < 6; k++) begin
            push(8'($urandom));
            if (k == 4) chk("full_after5", 0, full_w[0], 1'b1);
        end
        steps(1300);

        // A push clears a standing tx_done on the very next edge.
        chk("done_idle", 0, done_w[0], 1'b1);
        push(8'($urandom));
        chk("push_clr_done", 0, done_w[0], 1'b0);
        chk("push_busy", 0, busy_w[0], 1'b1);
        steps(300);

        // Asynchronous reset halfway through bit 3.
        push(8'h00);
        steps(58);
        chk("pre_rst_tx", 0, tx_w[0], 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            chk("arst_tx", i, tx_w[i], 1'b1);
            chk("arst_busy", i, busy_w[i], 1'b0);
            chk("arst_full", i, full_w[i], 1'b0);
            chk("arst_done", i, done_w[i], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        steps(300);

        // Random traffic, then drain.
        for (int n = 0; n < 3000; n++) begin
            trmt = ($urandom_range(0, 15) == 0);
            tx_data = 8'($urandom);
            step();
        end
        trmt = 1'b0;
        steps(1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
